// File: rtl/cic_ctrl_pkg.sv
// cic_ctrl_pkg: shared state encoding, default widths and counter-width helper for cic_decimator_ctrl
package cic_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SETTLE, S_RUN} state_t;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_PRESCALE_WIDTH = 8;
  localparam int DEF_FLUSH_CYCLES   = 4;
  localparam int DEF_SETTLE_SAMPLES = 3;
  localparam int DEF_COUNT_WIDTH    = 16;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cic_enable_strobe.sv
// cic_enable_strobe: prescaled enable strobe (clk, rst, i_load latches i_prescale, i_run counts, o_enabled strobe)
module cic_enable_strobe import cic_ctrl_pkg::*; #(
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load,
  input  logic                      i_run,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_enabled
);
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= '0;
      r_cnt      <= '0;
    end else begin
      if (i_load) r_prescale <= i_prescale;
      r_cnt <= (!i_run || r_cnt == r_prescale) ? '0 : r_cnt + 1'b1;
    end
  end
  assign o_enabled = i_run && (r_cnt == '0);
endmodule

// File: rtl/cic_decimator_ctrl.sv
// cic_decimator_ctrl: sequences a cic_decimator (flush, settle, run) and forwards settled samples over valid/ready
module cic_decimator_ctrl import cic_ctrl_pkg::*; #(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
  parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
  parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
  parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  output logic                      dec_rst_n,
  output logic                      dec_enabled,
  input  logic                      dec_clk_transfer,
  input  logic [DATA_WIDTH-1:0]     dec_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      busy,
  output logic                      overrun,
  output logic [COUNT_WIDTH-1:0]    sample_count
);
  localparam int FW = cnt_width(FLUSH_CYCLES);
  localparam int SW = cnt_width(SETTLE_SAMPLES);
  localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);
  state_t                  r_state;
  logic [FW-1:0]           r_flush_cnt;
  logic [SW-1:0]           r_settle_cnt;
  logic                    r_en_d1;
  logic                    r_valid;
  logic                    r_overrun;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    w_active;
  logic                    w_start;
  logic                    w_evt;
  logic                    w_run_evt;
  logic                    w_take;
  assign w_active  = (r_state == S_SETTLE) || (r_state == S_RUN);
  assign w_start   = (r_state == S_IDLE) && cfg_start && !cfg_stop;
  assign w_evt     = w_active && r_en_d1 && dec_clk_transfer;
  assign w_run_evt = w_evt && (r_state == S_RUN);
  assign w_take    = w_run_evt && (!r_valid || m_ready);
  cic_enable_strobe #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_start),
    .i_run     (w_active),
    .i_prescale(cfg_prescale),
    .o_enabled (dec_enabled)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_flush_cnt  <= '0;
      r_settle_cnt <= '0;
      r_en_d1      <= 1'b0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_data       <= '0;
      r_count      <= '0;
    end else if (cfg_stop && r_state != S_IDLE) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_en_d1 <= 1'b0;
    end else begin
      r_en_d1 <= dec_enabled;
      if (w_start) begin
        r_state     <= S_FLUSH;
        r_flush_cnt <= '0;
        r_overrun   <= 1'b0;
        r_count     <= '0;
      end
      if (r_state == S_FLUSH) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
        if (r_flush_cnt == FLUSH_LAST) begin
          r_state      <= S_SETTLE;
          r_settle_cnt <= '0;
        end
      end
      if (r_state == S_SETTLE && w_evt) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
        if (r_settle_cnt == SETTLE_LAST) r_state <= S_RUN;
      end
      if (w_take) begin
        r_data  <= dec_data;
        r_valid <= 1'b1;
        r_count <= r_count + 1'b1;
      end else if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end
      if (w_run_evt && r_valid && !m_ready) r_overrun <= 1'b1;
    end
  end
  assign dec_rst_n    = w_active;
  assign busy         = (r_state != S_IDLE);
  assign m_valid      = r_valid;
  assign m_data       = r_data;
  assign overrun      = r_overrun;
  assign sample_count = r_count;
endmodule

// File: tb/tb_cic_decimator_ctrl.sv
// tb_cic_decimator_ctrl: directed self-checking bench for cic_decimator_ctrl
module tb_cic_decimator_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [7:0]  cfg_prescale = 8'd0;
  logic        dec_rst_n;
  logic        dec_enabled;
  logic        dec_clk_transfer = 1'b0;
  logic [15:0] dec_data = 16'd0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        busy;
  logic        overrun;
  logic [3:0]  sample_count;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  cic_decimator_ctrl #(.COUNT_WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_stop        (cfg_stop),
    .cfg_prescale    (cfg_prescale),
    .dec_rst_n       (dec_rst_n),
    .dec_enabled     (dec_enabled),
    .dec_clk_transfer(dec_clk_transfer),
    .dec_data        (dec_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .busy            (busy),
    .overrun         (overrun),
    .sample_count    (sample_count)
  );
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic evt(input logic [15:0] d);
    dec_clk_transfer = 1'b1;
    dec_data = d;
    step();
    dec_clk_transfer = 1'b0;
  endtask
  task automatic run_to_run();
    cfg_prescale = 8'd0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (5) step();
    for (int k = 0; k < 3; k++) evt(16'hDE00 + 16'(k));
  endtask
  task automatic stop();
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    step();
    chk("rst_rstn", 32'(dec_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    chk("rst_valid", 32'(m_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_rstn", 32'(dec_rst_n), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(m_valid), 32'd0);
    chk("idle_data", 32'(m_data), 32'd0);
    chk("idle_count", 32'(sample_count), 32'd0);
    chk("idle_ovr", 32'(overrun), 32'd0);
    cfg_prescale = 8'd0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("flush_rstn0", 32'(dec_rst_n), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("flush_rstn", 32'(dec_rst_n), 32'd0);
    end
    step();
    chk("settle_rstn", 32'(dec_rst_n), 32'd1);
    chk("settle_en", 32'(dec_enabled), 32'd1);
    step();
    for (int k = 0; k < 3; k++) begin
      evt(16'hA000 + 16'(k));
      chk("discard_valid", 32'(m_valid), 32'd0);
      repeat (4) step();
    end
    evt(16'h1234);
    chk("first_valid", 32'(m_valid), 32'd1);
    chk("first_data", 32'(m_data), 32'h1234);
    chk("first_count", 32'(sample_count), 32'd1);
    step();
    chk("drain_valid", 32'(m_valid), 32'd0);
    chk("drain_data", 32'(m_data), 32'h1234);
    stop();
    chk("stop_busy", 32'(busy), 32'd0);
    cfg_prescale = 8'd3;
    dec_clk_transfer = 1'b1;
    dec_data = 16'h0BEE;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      chk("ps3_en", 32'(dec_enabled), 32'(i % 4 == 0));
      step();
    end
    repeat (5) step();
    chk("ps3_novalid", 32'(m_valid), 32'd0);
    step();
    chk("ps3_valid", 32'(m_valid), 32'd1);
    chk("ps3_count1", 32'(sample_count), 32'd1);
    repeat (4) step();
    chk("ps3_count2", 32'(sample_count), 32'd2);
    dec_clk_transfer = 1'b0;
    stop();
    run_to_run();
    m_ready = 1'b0;
    evt(16'h1111);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_data", 32'(m_data), 32'h1111);
    repeat (2) step();
    evt(16'h2222);
    chk("bp_hold", 32'(m_data), 32'h1111);
    chk("bp_ovr", 32'(overrun), 32'd1);
    chk("bp_count", 32'(sample_count), 32'd1);
    chk("bp_valid2", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    step();
    chk("bp_acc_valid", 32'(m_valid), 32'd0);
    chk("bp_acc_count", 32'(sample_count), 32'd1);
    chk("bp_acc_data", 32'(m_data), 32'h1111);
    stop();
    chk("bp_stop_ovr", 32'(overrun), 32'd1);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("restart_ovr", 32'(overrun), 32'd0);
    chk("restart_count", 32'(sample_count), 32'd0);
    stop();
    run_to_run();
    m_ready = 1'b0;
    evt(16'h5555);
    chk("sr_valid", 32'(m_valid), 32'd1);
    stop();
    chk("sr_busy", 32'(busy), 32'd0);
    chk("sr_valid0", 32'(m_valid), 32'd0);
    chk("sr_rstn", 32'(dec_rst_n), 32'd0);
    chk("sr_en", 32'(dec_enabled), 32'd0);
    chk("sr_count", 32'(sample_count), 32'd1);
    cfg_start = 1'b1;
    cfg_stop = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    chk("both_busy", 32'(busy), 32'd0);
    step();
    chk("both_busy2", 32'(busy), 32'd0);
    m_ready = 1'b1;
    run_to_run();
    for (int i = 0; i < 17; i++) evt(16'(i));
    chk("wrap_count", 32'(sample_count), 32'd1);
    chk("wrap_ovr", 32'(overrun), 32'd0);
    chk("wrap_data", 32'(m_data), 32'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_count", 32'(sample_count), 32'd0);
    chk("mrst_valid", 32'(m_valid), 32'd0);
    chk("mrst_data", 32'(m_data), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
